// File: rtl/data_mem_responder.sv
// ---------------------------------------------------------------------------
// data_mem_responder
//   Memory-side responder for the single-cycle core's data port. It holds the
//   word RAM and an MMIO page with a TX byte FIFO (valid/ready drain to a
//   serial sink), a status register and an optional cycle timer.
//   Loads are combinational because the core consumes o_rdata in the same
//   cycle. Every state update happens on the rising i_clk edge.
//
//   Optional feature macro: TIMER_EN
//     defined   : 32-bit free-running cycle timer at MMIO offset 0x8
//     undefined : no timer flops; offset 0x8 reads 0 and ignores writes
//
// Parameters
//   DEPTH_WORDS  RAM depth in 32-bit words (power of 2)
//   FIFO_DEPTH   TX FIFO entries (power of 2, >= 2)
//   MMIO_PAGE    value of addr[31:16] that selects the MMIO page
//
// Ports
//   i_clk        system clock, rising edge
//   i_rst        asynchronous reset, active low
//   i_mem_read   read strobe from core control
//   i_mem_write  write strobe from core control
//   i_addr       byte address (core alu_out)
//   i_wdata      store data (core reg_file_out_2)
//   o_rdata      load data, combinational
//   o_tx_data    FIFO head byte
//   o_tx_valid   FIFO non-empty
//   i_tx_ready   sink accepts o_tx_data this cycle
//   o_bus_err    sticky misaligned / unmapped access flag
// ---------------------------------------------------------------------------
module data_mem_responder #(
  parameter int unsigned DEPTH_WORDS = 256,
  parameter int unsigned FIFO_DEPTH  = 8,
  parameter logic [15:0] MMIO_PAGE   = 16'hFFFF
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_mem_read,
  input  logic        i_mem_write,
  input  logic [31:0] i_addr,
  input  logic [31:0] i_wdata,
  output logic [31:0] o_rdata,
  output logic [7:0]  o_tx_data,
  output logic        o_tx_valid,
  input  logic        i_tx_ready,
  output logic        o_bus_err
);

  localparam int unsigned RAM_AW  = $clog2(DEPTH_WORDS);
  localparam int unsigned FIFO_AW = $clog2(FIFO_DEPTH);
  localparam int unsigned CNT_W   = FIFO_AW + 1;

  localparam logic [31:0] RAM_BYTES = 32'(DEPTH_WORDS * 4);

  localparam logic [3:0] OFF_TXDATA = 4'h0;
  localparam logic [3:0] OFF_STATUS = 4'h4;
  localparam logic [3:0] OFF_TIMER  = 4'h8;
  localparam logic [3:0] OFF_CTRL   = 4'hC;

  // ---------------------------------------------------------------------
  // Address decode
  // ---------------------------------------------------------------------
  logic              w_access;
  logic              w_misaligned;
  logic              w_is_mmio;
  logic              w_is_ram;
  logic              w_ok;
  logic              w_err;
  logic              w_wr_ram;
  logic              w_wr_mmio;
  logic              w_wr_txdata;
  logic              w_wr_ctrl;
  logic [RAM_AW-1:0] w_ram_idx;

  assign w_access     = i_mem_read | i_mem_write;
  assign w_misaligned = (i_addr[1:0] != 2'b00);
  assign w_is_mmio    = (i_addr[31:16] == MMIO_PAGE);
  assign w_is_ram     = !w_is_mmio && (i_addr < RAM_BYTES);
  assign w_ok         = !w_misaligned && (w_is_mmio || w_is_ram);
  assign w_err        = w_access && !w_ok;
  assign w_ram_idx    = i_addr[RAM_AW+1:2];

  assign w_wr_ram     = i_mem_write && w_ok && w_is_ram;
  assign w_wr_mmio    = i_mem_write && w_ok && w_is_mmio;
  assign w_wr_txdata  = w_wr_mmio && (i_addr[3:0] == OFF_TXDATA);
  assign w_wr_ctrl    = w_wr_mmio && (i_addr[3:0] == OFF_CTRL);

  // ---------------------------------------------------------------------
  // Word RAM (contents not reset)
  // ---------------------------------------------------------------------
  logic [31:0] r_ram [DEPTH_WORDS];

  always_ff @(posedge i_clk) begin
    if (w_wr_ram) begin
      r_ram[w_ram_idx] <= i_wdata;
    end
  end

  // ---------------------------------------------------------------------
  // TX FIFO state
  // ---------------------------------------------------------------------
  logic [7:0]         r_fifo [FIFO_DEPTH];
  logic [FIFO_AW-1:0] r_head;
  logic [FIFO_AW-1:0] r_tail;
  logic [CNT_W-1:0]   r_count;
  logic               r_tx_valid;
  logic [7:0]         r_tx_data;
  logic               r_overflow;
  logic               r_bus_err;

  logic               w_empty;
  logic               w_full;
  logic               w_pop;
  logic               w_push;
  logic               w_drop;
  logic [FIFO_AW-1:0] w_head_nxt;
  logic [FIFO_AW-1:0] w_tail_nxt;
  logic [CNT_W-1:0]   w_count_nxt;
  logic               w_tx_valid_nxt;
  logic [7:0]         w_tx_data_nxt;

  assign w_empty = (r_count == '0);
  assign w_full  = (r_count == CNT_W'(FIFO_DEPTH));
  assign w_pop   = r_tx_valid && i_tx_ready;
  // A pop in the same edge frees the slot, so a full FIFO still accepts.
  assign w_push  = w_wr_txdata && (!w_full || w_pop);
  assign w_drop  = w_wr_txdata && w_full && !w_pop;

  // FIFO next-state, including the head byte presented after the edge
  always_comb begin
    w_head_nxt     = r_head;
    w_tail_nxt     = r_tail;
    w_count_nxt    = r_count;
    w_tx_valid_nxt = 1'b0;
    w_tx_data_nxt  = 8'h00;

    if (w_pop) begin
      w_head_nxt = r_head + FIFO_AW'(1);
    end
    if (w_push) begin
      w_tail_nxt = r_tail + FIFO_AW'(1);
    end
    case ({w_push, w_pop})
      2'b10:   w_count_nxt = r_count + CNT_W'(1);
      2'b01:   w_count_nxt = r_count - CNT_W'(1);
      default: w_count_nxt = r_count;
    endcase

    w_tx_valid_nxt = (w_count_nxt != '0);
    // The new head is the byte being written now when it lands at the head slot.
    if (w_tx_valid_nxt) begin
      if (w_push && (w_head_nxt == r_tail)) begin
        w_tx_data_nxt = i_wdata[7:0];
      end else begin
        w_tx_data_nxt = r_fifo[w_head_nxt];
      end
    end
  end

  // FIFO payload storage (no reset needed, guarded by count)
  always_ff @(posedge i_clk) begin
    if (w_push) begin
      r_fifo[r_tail] <= i_wdata[7:0];
    end
  end

  // FIFO control, TX outputs and sticky flags
  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      r_head     <= '0;
      r_tail     <= '0;
      r_count    <= '0;
      r_tx_valid <= 1'b0;
      r_tx_data  <= 8'h00;
      r_overflow <= 1'b0;
      r_bus_err  <= 1'b0;
    end else begin
      r_head     <= w_head_nxt;
      r_tail     <= w_tail_nxt;
      r_count    <= w_count_nxt;
      r_tx_valid <= w_tx_valid_nxt;
      r_tx_data  <= w_tx_data_nxt;

      if (w_drop) begin
        r_overflow <= 1'b1;
      end else if (w_wr_ctrl && i_wdata[1]) begin
        r_overflow <= 1'b0;
      end

      // A new error outranks a W1C in the same cycle.
      if (w_err) begin
        r_bus_err <= 1'b1;
      end else if (w_wr_ctrl && i_wdata[2]) begin
        r_bus_err <= 1'b0;
      end
    end
  end

  assign o_tx_valid = r_tx_valid;
  assign o_tx_data  = r_tx_data;
  assign o_bus_err  = r_bus_err;

  // ---------------------------------------------------------------------
  // Cycle timer
  // ---------------------------------------------------------------------
  logic [31:0] w_timer;

`ifdef TIMER_EN
  logic        w_wr_timer;
  logic [31:0] r_timer;

  assign w_wr_timer = w_wr_mmio && (i_addr[3:0] == OFF_TIMER);

  // Software load takes priority over the increment.
  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      r_timer <= 32'h0000_0000;
    end else if (w_wr_timer) begin
      r_timer <= i_wdata;
    end else begin
      r_timer <= r_timer + 32'd1;
    end
  end

  assign w_timer = r_timer;
`else
  assign w_timer = 32'h0000_0000;
`endif

  // ---------------------------------------------------------------------
  // Combinational load path
  // ---------------------------------------------------------------------
  logic [31:0] w_status;

  assign w_status = {23'b0, r_bus_err, r_overflow, w_full, w_empty, 5'(r_count)};

  always_comb begin
    o_rdata = 32'h0000_0000;
    if (i_mem_read && w_ok) begin
      if (w_is_ram) begin
        o_rdata = r_ram[w_ram_idx];
      end else begin
        case (i_addr[3:0])
          OFF_STATUS: o_rdata = w_status;
          OFF_TIMER:  o_rdata = w_timer;
          default:    o_rdata = 32'h0000_0000;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_data_mem_responder.sv
// ---------------------------------------------------------------------------
// tb_data_mem_responder
//   Directed bench. The stimulus side queues the expected load data and the
//   expected TX byte order; a monitor on the falling edge pops and compares
//   whenever a load is presented or a TX byte is handed to the sink.
// ---------------------------------------------------------------------------
module tb_data_mem_responder;

  localparam logic [31:0] A_TXDATA = 32'hFFFF_0000;
  localparam logic [31:0] A_STATUS = 32'hFFFF_0004;
  localparam logic [31:0] A_TIMER  = 32'hFFFF_0008;
  localparam logic [31:0] A_CTRL   = 32'hFFFF_000C;

  logic        clk;
  logic        rst;
  logic        mem_read;
  logic        mem_write;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic [31:0] rdata;
  logic [7:0]  tx_data;
  logic        tx_valid;
  logic        tx_ready;
  logic        bus_err;

  logic [31:0] exp_rd [$];
  logic [7:0]  exp_tx [$];
  int          n_tot;
  int          n_bad;

  data_mem_responder dut (
    .i_clk       (clk),
    .i_rst       (rst),
    .i_mem_read  (mem_read),
    .i_mem_write (mem_write),
    .i_addr      (addr),
    .i_wdata     (wdata),
    .o_rdata     (rdata),
    .o_tx_data   (tx_data),
    .o_tx_valid  (tx_valid),
    .i_tx_ready  (tx_ready),
    .o_bus_err   (bus_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tot++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h want 0x%08h", name, act, exp);
    end
  endtask

  // Monitor: compare every presented load and every accepted TX byte
  always @(negedge clk) begin
    if (rst && mem_read === 1'b1) begin
      if (exp_rd.size() == 0) begin
        n_tot++;
        n_bad++;
        $display("FAIL rdata_unexpected: got 0x%08h want no load", rdata);
      end else begin
        chk("rdata", rdata, exp_rd.pop_front());
      end
    end else if (!rst && mem_read === 1'b1) begin
      // Load presented while reset is held: still a valid combinational read.
      if (exp_rd.size() == 0) begin
        n_tot++;
        n_bad++;
        $display("FAIL rdata_unexpected: got 0x%08h want no load", rdata);
      end else begin
        chk("rdata_in_reset", rdata, exp_rd.pop_front());
      end
    end
    if (tx_valid === 1'b1 && tx_ready === 1'b1) begin
      if (exp_tx.size() == 0) begin
        n_tot++;
        n_bad++;
        $display("FAIL tx_unexpected: got 0x%02h want no byte", tx_data);
      end else begin
        chk("tx_data", 32'(tx_data), 32'(exp_tx.pop_front()));
      end
    end
  end

  // One bus cycle: inputs change just after a rising edge and are held to the next.
  task automatic drive(input logic rd, input logic wr, input logic [31:0] a,
                       input logic [31:0] d, input logic txr);
    mem_read  = rd;
    mem_write = wr;
    addr      = a;
    wdata     = d;
    tx_ready  = txr;
    @(posedge clk);
    #1;
  endtask

  task automatic wr32(input logic [31:0] a, input logic [31:0] d);
    drive(1'b0, 1'b1, a, d, 1'b0);
  endtask

  task automatic rd32(input logic [31:0] a, input logic [31:0] e);
    exp_rd.push_back(e);
    drive(1'b1, 1'b0, a, 32'h0, 1'b0);
  endtask

  task automatic idle(input logic txr);
    drive(1'b0, 1'b0, 32'h0, 32'h0, txr);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    n_tot     = 0;
    n_bad     = 0;
    rst       = 1'b0;
    mem_read  = 1'b1;
    mem_write = 1'b0;
    addr      = A_STATUS;
    wdata     = 32'h0;
    tx_ready  = 1'b0;
    exp_rd.push_back(32'h0000_0020);
    #2;
    chk("reset_tx_valid", 32'(tx_valid), 32'h0);
    chk("reset_tx_data", 32'(tx_data), 32'h0);
    chk("reset_bus_err", 32'(bus_err), 32'h0);
    @(negedge clk);
    #1;
    rst      = 1'b1;
    mem_read = 1'b0;
    @(posedge clk);
    #1;

    // Reset in the middle of traffic
    rd32(32'h0000_0041, 32'h0);
    chk("pre_reset_bus_err", 32'(bus_err), 32'h1);
    wr32(A_TXDATA, 32'h11);
    wr32(A_TXDATA, 32'h22);
    wr32(A_TXDATA, 32'h33);
    chk("pre_reset_tx_valid", 32'(tx_valid), 32'h1);
    mem_read  = 1'b1;
    mem_write = 1'b0;
    addr      = A_STATUS;
    exp_rd.push_back(32'h0000_0020);
    rst       = 1'b0;
    #1;
    chk("midrst_tx_valid", 32'(tx_valid), 32'h0);
    chk("midrst_tx_data", 32'(tx_data), 32'h0);
    chk("midrst_bus_err", 32'(bus_err), 32'h0);
    @(negedge clk);
    #1;
    rst      = 1'b1;
    mem_read = 1'b0;
    @(posedge clk);
    #1;
    rd32(A_STATUS, 32'h0000_0020);

    // RAM store/load, read-old-data on simultaneous access
    wr32(32'h0000_0040, 32'h1234_5678);
    rd32(32'h0000_0040, 32'h1234_5678);
    exp_rd.push_back(32'h1234_5678);
    drive(1'b1, 1'b1, 32'h0000_0040, 32'hAAAA_AAAA, 1'b0);
    rd32(32'h0000_0040, 32'hAAAA_AAAA);
    wr32(32'h0000_03FC, 32'hDEAD_BEEF);
    rd32(32'h0000_03FC, 32'hDEAD_BEEF);
    chk("ram_no_err", 32'(bus_err), 32'h0);

    // Overflow with sink stalled, then ordered drain
    chk("fifo_empty_before", 32'(tx_valid), 32'h0);
    for (int i = 1; i <= 9; i++) begin
      wr32(A_TXDATA, 32'(i));
      if (i <= 8) exp_tx.push_back(8'(i));
      if (i == 1) begin
        chk("first_push_valid", 32'(tx_valid), 32'h1);
        chk("first_push_data", 32'(tx_data), 32'h01);
      end
    end
    rd32(A_STATUS, 32'h0000_00C8);
    repeat (8) idle(1'b1);
    chk("drained_tx_valid", 32'(tx_valid), 32'h0);
    rd32(A_STATUS, 32'h0000_00A0);
    wr32(A_CTRL, 32'h2);
    rd32(A_STATUS, 32'h0000_0020);

    // Push into a full FIFO while the head is popped
    for (int i = 0; i < 8; i++) begin
      wr32(A_TXDATA, 32'hA0 + 32'(i));
      exp_tx.push_back(8'hA0 + 8'(i));
    end
    rd32(A_STATUS, 32'h0000_0048);
    exp_tx.push_back(8'h55);
    drive(1'b0, 1'b1, A_TXDATA, 32'h55, 1'b1);
    rd32(A_STATUS, 32'h0000_0048);
    repeat (8) idle(1'b1);
    chk("full_pp_drained", 32'(tx_valid), 32'h0);
    rd32(A_STATUS, 32'h0000_0020);

    // Bus errors and W1C clear
    rd32(32'h0000_0041, 32'h0);
    chk("misaligned_err", 32'(bus_err), 32'h1);
    rd32(A_STATUS, 32'h0000_0120);
    wr32(A_CTRL, 32'h4);
    chk("w1c_clear", 32'(bus_err), 32'h0);
    rd32(32'h0000_4000, 32'h0);
    chk("unmapped_err", 32'(bus_err), 32'h1);
    wr32(A_CTRL, 32'h4);
    rd32(32'h0000_0400, 32'h0);
    chk("first_unmapped_err", 32'(bus_err), 32'h1);
    wr32(A_CTRL, 32'h4);
    drive(1'b0, 1'b1, 32'h0000_0042, 32'h0, 1'b0);
    chk("misaligned_wr_err", 32'(bus_err), 32'h1);
    rd32(32'h0000_0040, 32'hAAAA_AAAA);
    wr32(A_CTRL, 32'h4);
    rd32(A_TXDATA, 32'h0);
    chk("final_err_clear", 32'(bus_err), 32'h0);

    // Timer load and wrap
    wr32(A_TIMER, 32'hFFFF_FFFE);
`ifdef TIMER_EN
    rd32(A_TIMER, 32'hFFFF_FFFE);
`else
    rd32(A_TIMER, 32'h0);
`endif
    idle(1'b0);
    rd32(A_TIMER, 32'h0);

    idle(1'b0);
    idle(1'b0);
    chk("rd_queue_left", 32'(exp_rd.size()), 32'h0);
    chk("tx_queue_left", 32'(exp_tx.size()), 32'h0);

    $display("test done: total=%0d bad=%0d", n_tot, n_bad);
    $finish;
  end

endmodule
